dff: RTL and testbench



---
 rtl/dff.sv | 39 +++
 tb/tb_dff.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dff.sv
// dff: D-type storage register with an optional chain of identical stages.
// Every stage loads RESET_VALUE asynchronously while rst is low; q is the last stage.
module dff #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              STAGES      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Illegal geometries stop elaboration instead of building a malformed chain.
    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("dff: STAGES must be in 1..16");
    end
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("dff: WIDTH must be in 1..1024");
    end

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= RESET_VALUE;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule

// File: tb/tb_dff.sv
// tb_dff: directed vector bench for dff, driving a 1-bit single-stage instance
// and an 8-bit three-stage instance (RESET_VALUE 8'hA5) from a shared reset.
module tb_dff;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       rst;
        logic       d1;
        logic       expQ1;
        logic [7:0] d8;
        logic [7:0] expQ8;
    } vector_t;

    vector_t vectors [8];

    dff #(.WIDTH(1), .RESET_VALUE(1'b0), .STAGES(1)) dutSingle (
        .clk(clk),
        .rst(rst),
        .d  (d1),
        .q  (q1)
    );

    dff #(.WIDTH(8), .RESET_VALUE(8'hA5), .STAGES(3)) dutChain (
        .clk(clk),
        .rst(rst),
        .d  (d8),
        .q  (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge so they are stable around the next rising edge.
    task automatic applyStimulus(input vector_t v);
        @(negedge clk);
        rst = v.rst;
        d1  = v.d1;
        d8  = v.d8;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vectors[0] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5};
        vectors[1] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5};
        vectors[2] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'hA5};
        vectors[3] = '{1'b1, 1'b1, 1'b1, 8'h02, 8'hA5};
        vectors[4] = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h01};
        vectors[5] = '{1'b1, 1'b1, 1'b1, 8'h04, 8'h02};
        vectors[6] = '{1'b1, 1'b1, 1'b1, 8'h05, 8'h03};
        vectors[7] = '{1'b1, 1'b0, 1'b0, 8'h06, 8'h04};

        rst = 1'b1;
        d1  = 1'b1;
        d8  = 8'hFF;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("powerup_async_q1", {7'd0, q1}, 8'h00);
        checkOutput("powerup_async_q8", q8, 8'hA5);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_q1", i), {7'd0, q1}, {7'd0, vectors[i].expQ1});
            checkOutput($sformatf("vec%0d_q8", i), q8, vectors[i].expQ8);
        end

        // A pulse on d that starts and ends between edges must never reach q.
        #1;
        d1 = 1'b1;
        #3;
        checkOutput("glitch_mid", {7'd0, q1}, 8'h00);
        d1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("glitch_after_edge", {7'd0, q1}, 8'h00);

        // Mid-cycle reset clears q at once; release between edges waits for the next edge.
        d1 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_q1", {7'd0, q1}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_assert_q1", {7'd0, q1}, 8'h00);
        checkOutput("async_assert_q8", q8, 8'hA5);
        #2;
        rst = 1'b1;
        d1  = 1'b1;
        #2;
        checkOutput("release_hold_q1", {7'd0, q1}, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("release_capture_q1", {7'd0, q1}, 8'h01);
        checkOutput("release_chain_q8", q8, 8'hA5);

        // Release scheduled on the edge itself: that edge still sees reset.
        #2;
        rst = 1'b0;
        d1  = 1'b1;
        d8  = 8'h11;
        @(posedge clk);
        rst <= 1'b1;
        #1;
        checkOutput("coincident_edge_q1", {7'd0, q1}, 8'h00);
        checkOutput("coincident_edge_q8", q8, 8'hA5);
        @(posedge clk);
        #1;
        checkOutput("coincident_next_q1", {7'd0, q1}, 8'h01);
        checkOutput("coincident_next_q8", q8, 8'hA5);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("coincident_chain_q8", q8, 8'h11);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
